dma_copy_ctrl: RTL and testbench
================================

DMA_COPY_CTRL -- requirements
Module: dma_copy_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, shall set the width of the RAM address and all address/length ports.
REQ-002 Parameter DATA_WIDTH, default 8, shall set the width of the RAM data ports and fill_value.
REQ-003 clk  input  1  shall be the single clock; all state changes occur on its rising edge.
REQ-004 reset_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 start  input  1  shall request a transfer; it is sampled only in IDLE.
REQ-006 mode  input  1  shall select copy (0) or fill (1); it is latched on accepted start.
REQ-007 src_addr  input  ADDR_WIDTH  shall be the copy source base; it is latched on accepted start.
REQ-008 dst_addr  input  ADDR_WIDTH  shall be the destination base; it is latched on accepted start.
REQ-009 length  input  ADDR_WIDTH  shall be the byte count; it is latched on accepted start.
REQ-010 fill_value  input  DATA_WIDTH  shall be the fill pattern; it is latched on accepted start.
REQ-011 abort  input  1  shall request termination of an active transfer.
REQ-012 busy  output  1  shall be high while in READ or WRITE.
REQ-013 done  output  1  shall be a one-cycle pulse at transfer completion or abort.
REQ-014 aborted  output  1  shall be high with done when the transfer ended by abort, and low otherwise.
REQ-015 count  output  ADDR_WIDTH  shall report the number of bytes written so far in the current or last transfer.
REQ-016 address  output  ADDR_WIDTH  shall drive the RAM address.
REQ-017 data  output  DATA_WIDTH  shall drive the RAM write data.
REQ-018 read_signal  output  1  shall drive the RAM read strobe.
REQ-019 write_signal  output  1  shall drive the RAM write strobe.
REQ-020 dataout  input  DATA_WIDTH  shall carry the RAM read data, which is valid in the same cycle read_signal is high.

Function
REQ-021 The FSM shall have the states IDLE, READ, WRITE and DONE, and all outputs shall be registered.
REQ-022 In IDLE, start=1 with length>0 shall latch the inputs, clear count, and move to READ (mode 0) or WRITE (mode 1).
REQ-023 In IDLE, start=1 with length=0 shall go to DONE without any RAM access and leave count at 0.
REQ-024 In READ, the block shall drive read_signal=1 and address=src+count, and capture dataout into the write buffer at the end of the cycle.
REQ-025 In WRITE, the block shall drive write_signal=1 and address=dst+count, with data equal to the write buffer (copy) or fill_value (fill).
REQ-026 After each WRITE cycle, count shall increment; the next state is DONE if count+1==length, otherwise READ (copy) or WRITE (fill).
REQ-027 A copy transfer shall take 2 cycles per byte and a fill transfer 1 cycle per byte.
REQ-028 Address arithmetic shall wrap modulo 2^ADDR_WIDTH, with no error raised on wrap.
REQ-029 read_signal and write_signal shall never be high in the same cycle, and both shall be 0 outside READ and WRITE.
REQ-030 DONE shall last exactly one cycle with done=1, then return to IDLE; start is ignored in DONE.
REQ-031 abort=1 in READ shall go to DONE with aborted=1 and suppress the pending write.
REQ-032 abort=1 in WRITE shall let that write complete and count it, then go to DONE with aborted=1.
REQ-033 abort=1 in IDLE or DONE shall be ignored, and abort shall take priority over normal completion in the same cycle.
REQ-034 Start and abort arriving together in IDLE shall start the transfer, with the abort ignored.
REQ-035 Overlapping source and destination ranges shall be copied in ascending address order, with no overlap correction.

Reset
REQ-036 On reset_n=0 the FSM shall enter IDLE immediately, and busy, done, aborted, read_signal and write_signal shall go to 0, with count, address and data at 0.
REQ-037 Reset during a transfer shall terminate it at once with no further RAM strobe and no done pulse.
REQ-038 Operation shall resume on the first rising clk edge after reset_n returns high.

Verification
REQ-039 Copy src=0x0010, dst=0x0100, length=4 over RAM preset 0xA0..0xA3 -> RAM[0x100..0x103]=0xA0..0xA3, busy high for 8 cycles, done pulse, count=4, aborted=0.
REQ-040 Fill dst=0x7FFE, length=3, fill_value=0x5A -> writes to 0x7FFE, 0x7FFF, 0x8000 on consecutive cycles, count=3.
REQ-041 Copy with length=0 -> done on the cycle after start, no strobes, count=0.
REQ-042 Copy dst=0xFFFF, length=2 -> second write goes to 0x0000 (wrap).
REQ-043 Copy length=10, abort asserted in the READ of byte 3 -> count=2, aborted=1, only two writes occur.
REQ-044 Fill length=8, reset_n pulsed low mid-transfer -> strobes drop asynchronously, no done pulse, IDLE after release, and a new start is accepted.

Source files
------------

// File: rtl/dma_copy_ctrl.sv
// DMA copy/fill controller: moves bytes between RAM regions or fills one.
// One RAM port; copy takes a read and a write cycle per byte, fill takes a write.
module dma_copy_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH-1:0] count,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  read_signal,
  output logic                  write_signal,
  input  logic [DATA_WIDTH-1:0] dataout
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [ADDR_WIDTH-1:0] cnt_inc;

  assign cnt_inc = count_q + 1'b1;

  // Next state and next registered outputs; data_q doubles as the write buffer.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    fill_d    = fill_q;
    count_d   = count_q;
    address_d = address_q;
    data_d    = data_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          fill_d  = fill_value;
          count_d = '0;
          if (length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (mode) begin
            state_d   = WRITE;
            wr_d      = 1'b1;
            busy_d    = 1'b1;
            address_d = dst_addr;
            data_d    = fill_value;
          end else begin
            state_d   = READ;
            rd_d      = 1'b1;
            busy_d    = 1'b1;
            address_d = src_addr;
          end
        end
      end
      READ: begin
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          state_d   = WRITE;
          wr_d      = 1'b1;
          busy_d    = 1'b1;
          address_d = dst_q + count_q;
          data_d    = dataout;
        end
      end
      WRITE: begin
        count_d = cnt_inc;
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_inc == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (mode_q) begin
          state_d   = WRITE;
          wr_d      = 1'b1;
          busy_d    = 1'b1;
          address_d = dst_q + cnt_inc;
          data_d    = fill_q;
        end else begin
          state_d   = READ;
          rd_d      = 1'b1;
          busy_d    = 1'b1;
          address_d = src_q + cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      address_q <= '0;
      data_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      address_q <= address_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign count        = count_q;
  assign address      = address_q;
  assign data         = data_q;
  assign read_signal  = rd_q;
  assign write_signal = wr_q;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl with a 64K x 8 RAM model.
// Strobe/busy/done activity is tallied at each rising edge.
module tb_dma_copy_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic [7:0]  fill_value = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [15:0] count, address;
  logic [7:0]  data, dataout;
  logic        read_signal, write_signal;

  logic [7:0]  mem [0:65535];
  logic [15:0] wlog [0:255];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  int n_wr = 0, n_rd = 0, n_busy = 0, n_done = 0, n_ovl = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dma_copy_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .count(count), .address(address), .data(data),
    .read_signal(read_signal), .write_signal(write_signal),
    .dataout(dataout)
  );

  assign dataout = mem[address];

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    if (write_signal) begin
      mem[address] <= data;
      wlog[n_wr[7:0]] <= address;
      n_wr <= n_wr + 1;
    end
    if (read_signal) n_rd <= n_rd + 1;
    if (busy) n_busy <= n_busy + 1;
    if (done) n_done <= n_done + 1;
    if (read_signal && write_signal) n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic go(input logic m, input logic [15:0] s,
                    input logic [15:0] d, input logic [15:0] n,
                    input logic [7:0] f);
    @(negedge clk);
    mode = m;
    src_addr = s;
    dst_addr = d;
    length = n;
    fill_value = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int b_wr, b_rd, b_busy, b_done, cyc;

  task automatic snap();
    b_wr = n_wr;
    b_rd = n_rd;
    b_busy = n_busy;
    b_done = n_done;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {read_signal, write_signal, aborted}, 0);
    chk("rst_count", count, 0);
    chk("rst_addr_data", {address, data}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), 8'hA0 + 8'(i));
    poke(16'h0020, 8'hB1);
    poke(16'h0021, 8'hB2);

    // copy 4 bytes
    snap();
    go(1'b0, 16'h0010, 16'h0100, 16'd4, 8'h00);
    chk("cp_first_rd", {read_signal, write_signal, address}, {2'b10, 16'h0010});
    wait_done(cyc);
    chk("cp_done", done, 1);
    chk("cp_count", count, 4);
    chk("cp_aborted", aborted, 0);
    chk("cp_busy_cycles", n_busy - b_busy, 8);
    @(negedge clk);
    chk("cp_done_pulse", {done, 16'(n_done - b_done)}, {1'b0, 16'd1});
    chk("cp_nwr", n_wr - b_wr, 4);
    chk("cp_nrd", n_rd - b_rd, 4);
    for (int i = 0; i < 4; i++)
      chk("cp_mem", mem[16'h0100 + 16'(i)], 8'hA0 + 8'(i));

    // fill crossing 0x8000
    snap();
    go(1'b1, 16'h0000, 16'h7FFE, 16'd3, 8'h5A);
    wait_done(cyc);
    chk("fl_count", count, 3);
    chk("fl_busy_cycles", n_busy - b_busy, 3);
    chk("fl_nrd", n_rd - b_rd, 0);
    chk("fl_wa0", wlog[8'(b_wr)], 16'h7FFE);
    chk("fl_wa1", wlog[8'(b_wr + 1)], 16'h7FFF);
    chk("fl_wa2", wlog[8'(b_wr + 2)], 16'h8000);
    chk("fl_mem", mem[16'h8000], 8'h5A);

    // zero length
    @(negedge clk);
    snap();
    go(1'b0, 16'h0010, 16'h0900, 16'd0, 8'h00);
    chk("z_done_next", done, 1);
    chk("z_count", count, 0);
    @(negedge clk);
    chk("z_strobes", (n_wr - b_wr) + (n_rd - b_rd) + (n_busy - b_busy), 0);
    chk("z_done_once", {done, 16'(n_done - b_done)}, {1'b0, 16'd1});

    // copy wrapping destination
    snap();
    go(1'b0, 16'h0020, 16'hFFFF, 16'd2, 8'h00);
    wait_done(cyc);
    chk("wr_count", count, 2);
    chk("wr_wa1", wlog[8'(b_wr + 1)], 16'h0000);
    chk("wr_mem0", mem[16'h0000], 8'hB2);
    chk("wr_memF", mem[16'hFFFF], 8'hB1);

    // abort in READ of byte 3
    @(negedge clk);
    snap();
    go(1'b0, 16'h0010, 16'h0200, 16'd10, 8'h00);
    repeat (4) @(negedge clk);
    chk("ab_in_read", {read_signal, count}, {1'b1, 16'd2});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_done", {done, aborted}, 2'b11);
    chk("ab_count", count, 2);
    chk("ab_nwr", n_wr - b_wr, 2);
    @(negedge clk);
    chk("ab_nwr_after", n_wr - b_wr, 2);

    // abort in WRITE of a fill
    snap();
    go(1'b1, 16'h0000, 16'h0300, 16'd5, 8'h33);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("aw_done", {done, aborted}, 2'b11);
    chk("aw_count", count, 1);
    chk("aw_mem", mem[16'h0300], 8'h33);

    // start with abort in IDLE: abort ignored
    @(negedge clk);
    abort = 1'b1;
    go(1'b0, 16'h0010, 16'h0400, 16'd1, 8'h00);
    abort = 1'b0;
    wait_done(cyc);
    chk("sa_aborted", aborted, 0);
    chk("sa_count", count, 1);
    @(negedge clk);
    chk("sa_mem", mem[16'h0400], 8'hA0);

    // reset in mid-fill
    snap();
    go(1'b1, 16'h0000, 16'h0500, 16'd8, 8'hC3);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_strobes", {read_signal, write_signal, busy, done}, 0);
    chk("rs_count_addr", {count, address}, 0);
    chk("rs_nwr", n_wr - b_wr, 2);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rs_no_done", n_done - b_done, 0);
    chk("rs_no_wr", n_wr - b_wr, 2);
    go(1'b1, 16'h0000, 16'h0600, 16'd1, 8'h77);
    wait_done(cyc);
    chk("rs_restart_cnt", count, 1);
    @(negedge clk);
    chk("rs_restart_mem", mem[16'h0600], 8'h77);
    chk("no_overlap", n_ovl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
